// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA scan-out that reads grayscale bytes over the memory IO
// port and re-aligns sync/blank/frame flags to the memory read latency.
module vga_frame_reader #(
    parameter int          CLK_DIV    = 2,
    parameter int          RD_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 256,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] address_IO,
    input  logic [7:0]  q_IO,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [31:0] C_IMG_W   = 32'(IMG_W);
    localparam logic [31:0] C_IMG_H   = 32'(IMG_H);
    localparam logic [31:0] C_IMG_HM1 = 32'(IMG_H - 1);
    localparam logic [31:0] C_HA      = 32'(H_ACTIVE);
    localparam logic [31:0] C_VA      = 32'(V_ACTIVE);
    localparam logic [31:0] C_HS0     = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] C_HS1     = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] C_VS0     = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] C_VS1     = 32'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic active;
        logic in_img;
        logic hs_low;
        logic vs_low;
        logic fs;
    } pos_t;

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] r_v;
    logic [VW-1:0] w_v_nxt;
    logic [31:0]   r_row_base;
    logic [31:0]   w_row_nxt;
    logic [31:0]   r_addr;
    logic [31:0]   w_addr;
    logic [31:0]   w_hx;
    logic [31:0]   w_vx;
    logic          w_tick;
    logic          w_h_wrap;
    logic          w_in_img;
    pos_t          w_pos;
    pos_t          r_dly [RD_LATENCY];
    pos_t          w_tail;
    logic [7:0]    r_gray;
    logic          r_hs;
    logic          r_vs;
    logic          r_blank_n;
    logic          r_fs;

    assign w_tick   = (r_div == DW'(CLK_DIV - 1));
    assign w_h_wrap = w_tick && (r_h == HW'(H_TOTAL - 1));

    // Next scan position; everything downstream is derived from these values
    // so the address and stage 0 of the delay line move on the same edge.
    always_comb begin
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        w_row_nxt = r_row_base;
        if (w_h_wrap) begin
            w_h_nxt = '0;
            if (r_v == VW'(V_TOTAL - 1)) begin
                w_v_nxt   = '0;
                w_row_nxt = BASE_ADDR;
            end else begin
                w_v_nxt = r_v + 1'b1;
                if (32'(r_v) < C_IMG_HM1)
                    w_row_nxt = r_row_base + C_IMG_W;
            end
        end else if (w_tick) begin
            w_h_nxt = r_h + 1'b1;
        end
    end

    assign w_hx     = 32'(w_h_nxt);
    assign w_vx     = 32'(w_v_nxt);
    assign w_in_img = (w_hx < C_IMG_W) && (w_vx < C_IMG_H);
    assign w_addr   = w_in_img ? (w_row_nxt + w_hx) : BASE_ADDR;

    always_comb begin
        w_pos        = '0;
        w_pos.active = (w_hx < C_HA) && (w_vx < C_VA);
        w_pos.in_img = w_in_img;
        w_pos.hs_low = (w_hx >= C_HS0) && (w_hx < C_HS1);
        w_pos.vs_low = (w_vx >= C_VS0) && (w_vx < C_VS1);
        w_pos.fs     = w_tick && (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_h        <= '0;
            r_v        <= '0;
            r_row_base <= BASE_ADDR;
            r_addr     <= BASE_ADDR;
        end else begin
            r_div      <= w_tick ? '0 : r_div + 1'b1;
            r_h        <= w_h_nxt;
            r_v        <= w_v_nxt;
            r_row_base <= w_row_nxt;
            r_addr     <= w_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++)
                r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_pos;
            for (int i = 1; i < RD_LATENCY; i++)
                r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_tail = r_dly[RD_LATENCY-1];

    // q_IO belongs to the address issued RD_LATENCY edges ago, i.e. w_tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray    <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_fs      <= 1'b0;
        end else begin
            r_gray    <= (w_tail.active && w_tail.in_img) ? q_IO : 8'h00;
            r_hs      <= ~w_tail.hs_low;
            r_vs      <= ~w_tail.vs_low;
            r_blank_n <= w_tail.active;
            r_fs      <= w_tail.fs;
        end
    end

    assign address_IO  = r_addr;
    assign vga_r       = r_gray;
    assign vga_g       = r_gray;
    assign vga_b       = r_gray;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign frame_start = r_fs;

endmodule
